// File: rtl/crossbar_pkg.sv
// Shared constants and address decode helper for the round-robin crossbar.
package crossbar_pkg;

  localparam logic CMD_READ  = 1'b0;
  localparam logic CMD_WRITE = 1'b1;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_BUSY = 1'b1;

  // Slave index = top sel_w bits of an addr_w-wide address (addr_w <= 64).
  function automatic int unsigned sel_of(input logic [63:0] addr,
                                         input int unsigned addr_w,
                                         input int unsigned sel_w);
    logic [63:0] sh;
    sh = addr >> (addr_w - sel_w);
    return 32'(sh & ((64'd1 << sel_w) - 64'd1));
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first request at or after the pointer.
module rr_arbiter #(
  parameter int N = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] i_req,
  input  logic         i_advance,
  output logic [N-1:0] o_gnt
);
  localparam int PTR_W = (N > 1) ? $clog2(N) : 1;

  logic [PTR_W-1:0] r_ptr;
  logic [PTR_W-1:0] w_ptr_next;
  logic [PTR_W-1:0] w_idx;
  logic             w_found;
  int               w_j;

  always_comb begin
    o_gnt      = '0;
    w_ptr_next = r_ptr;
    w_found    = 1'b0;
    w_idx      = '0;
    w_j        = 0;
    for (int k = 0; k < N; k++) begin
      w_j = int'(r_ptr) + k;
      if (w_j >= N) w_j = w_j - N;
      w_idx = PTR_W'(w_j);
      if (!w_found && i_req[w_idx]) begin
        w_found      = 1'b1;
        o_gnt[w_idx] = 1'b1;
        w_ptr_next   = (w_j == N - 1) ? '0 : PTR_W'(w_j + 1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)            r_ptr <= '0;
    else if (i_advance) r_ptr <= w_ptr_next;
  end

endmodule

// File: rtl/crossbar_rr.sv
// N-master x M-slave req/ack crossbar with an independent round-robin arbiter per slave.
module crossbar_rr
  import crossbar_pkg::*;
#(
  parameter int N_MST  = 2,
  parameter int N_SLV  = 2,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_MST-1:0]          master_req,
  input  logic [N_MST-1:0]          master_cmd,
  input  logic [N_MST*ADDR_W-1:0]   master_addr,
  input  logic [N_MST*DATA_W-1:0]   master_wdata,
  output logic [N_MST-1:0]          master_ack,
  output logic [N_MST-1:0]          master_err,
  output logic [N_MST*DATA_W-1:0]   master_rdata,
  output logic [N_SLV-1:0]          slave_req,
  output logic [N_SLV-1:0]          slave_cmd,
  output logic [N_SLV*ADDR_W-1:0]   slave_addr,
  output logic [N_SLV*DATA_W-1:0]   slave_wdata,
  input  logic [N_SLV-1:0]          slave_ack,
  input  logic [N_SLV*DATA_W-1:0]   slave_rdata
);
  localparam int SEL_W = (N_SLV > 1) ? $clog2(N_SLV) : 1;
  localparam int OWN_W = (N_MST > 1) ? $clog2(N_MST) : 1;

  logic [N_MST*SEL_W-1:0] w_sel_flat;
  logic [N_MST-1:0]       w_dec_err;
  logic [N_MST-1:0]       w_busy;
  logic [N_MST-1:0]       w_avail;
  logic [N_SLV-1:0]       w_slv_busy;
  logic [N_SLV-1:0]       w_done;
  logic [N_SLV*OWN_W-1:0] w_owner_flat;

  // A master is unavailable while it owns a slave and during its ack cycle.
  always_comb begin
    w_busy = '0;
    for (int i = 0; i < N_MST; i++)
      for (int s = 0; s < N_SLV; s++)
        if (w_slv_busy[s] && int'(w_owner_flat[s*OWN_W +: OWN_W]) == i) w_busy[i] = 1'b1;
  end
  assign w_avail = ~(w_busy | master_ack);

  for (genvar gi = 0; gi < N_MST; gi++) begin : gen_dec
    assign w_sel_flat[gi*SEL_W +: SEL_W] =
      SEL_W'(sel_of(64'(master_addr[gi*ADDR_W +: ADDR_W]), ADDR_W, SEL_W));
    assign w_dec_err[gi] = master_req[gi] && w_avail[gi] &&
                           (int'(w_sel_flat[gi*SEL_W +: SEL_W]) >= N_SLV);
  end

  for (genvar gs = 0; gs < N_SLV; gs++) begin : gen_slv
    logic [0:0]        r_state;
    logic              r_req;
    logic              r_cmd;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [OWN_W-1:0]  r_owner;
    logic [N_MST-1:0]  w_cand;
    logic [N_MST-1:0]  w_gnt;
    logic              w_adv;
    logic [OWN_W-1:0]  w_gidx;
    logic              w_gcmd;
    logic [ADDR_W-1:0] w_gaddr;
    logic [DATA_W-1:0] w_gwdata;

    always_comb begin
      w_cand = '0;
      for (int i = 0; i < N_MST; i++)
        w_cand[i] = master_req[i] && w_avail[i] &&
                    (int'(w_sel_flat[i*SEL_W +: SEL_W]) == gs);
    end

    assign w_adv = (r_state == ST_IDLE) && (|w_cand);

    rr_arbiter #(.N(N_MST)) u_arb (
      .clk       (clk),
      .rst       (rst),
      .i_req     (w_cand),
      .i_advance (w_adv),
      .o_gnt     (w_gnt)
    );

    always_comb begin
      w_gidx   = '0;
      w_gcmd   = 1'b0;
      w_gaddr  = '0;
      w_gwdata = '0;
      for (int i = 0; i < N_MST; i++) begin
        if (w_gnt[i]) begin
          w_gidx   = OWN_W'(i);
          w_gcmd   = master_cmd[i];
          w_gaddr  = master_addr[i*ADDR_W +: ADDR_W];
          w_gwdata = master_wdata[i*DATA_W +: DATA_W];
        end
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_state <= ST_IDLE;
        r_req   <= 1'b0;
        r_cmd   <= 1'b0;
        r_addr  <= '0;
        r_wdata <= '0;
        r_owner <= '0;
      end else if (r_state == ST_IDLE) begin
        if (w_adv) begin
          r_state <= ST_BUSY;
          r_req   <= 1'b1;
          r_cmd   <= w_gcmd;
          r_addr  <= w_gaddr;
          r_wdata <= w_gwdata;
          r_owner <= w_gidx;
        end
      end else if (slave_ack[gs]) begin
        r_state <= ST_IDLE;
        r_req   <= 1'b0;
      end
    end

    assign slave_req[gs]                     = r_req;
    assign slave_cmd[gs]                     = r_cmd;
    assign slave_addr[gs*ADDR_W +: ADDR_W]   = r_addr;
    assign slave_wdata[gs*DATA_W +: DATA_W]  = r_wdata;
    assign w_slv_busy[gs]                    = (r_state == ST_BUSY);
    assign w_done[gs]                        = (r_state == ST_BUSY) && slave_ack[gs];
    assign w_owner_flat[gs*OWN_W +: OWN_W]   = r_owner;
  end

  for (genvar gi = 0; gi < N_MST; gi++) begin : gen_mst
    logic              r_ack;
    logic              r_err;
    logic [DATA_W-1:0] r_rdata;
    logic              w_ack_next;
    logic              w_rd_hit;
    logic [DATA_W-1:0] w_rd_val;

    always_comb begin
      w_ack_next = w_dec_err[gi];
      w_rd_hit   = 1'b0;
      w_rd_val   = '0;
      for (int s = 0; s < N_SLV; s++) begin
        if (w_done[s] && int'(w_owner_flat[s*OWN_W +: OWN_W]) == gi) begin
          w_ack_next = 1'b1;
          if (slave_cmd[s] == CMD_READ) begin
            w_rd_hit = 1'b1;
            w_rd_val = slave_rdata[s*DATA_W +: DATA_W];
          end
        end
      end
    end

    // Read data is held until the next read completion or decode error.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_ack   <= 1'b0;
        r_err   <= 1'b0;
        r_rdata <= '0;
      end else begin
        r_ack <= w_ack_next;
        r_err <= w_dec_err[gi];
        if (w_dec_err[gi])  r_rdata <= '0;
        else if (w_rd_hit)  r_rdata <= w_rd_val;
      end
    end

    assign master_ack[gi]                    = r_ack;
    assign master_err[gi]                    = r_err;
    assign master_rdata[gi*DATA_W +: DATA_W] = r_rdata;
  end

endmodule

// File: tb/tb_crossbar_rr.sv
// Directed bench for crossbar_rr: 4 masters, 3 slaves (slave = addr[31:30], 3 = decode error).
module tb_crossbar_rr;
  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [3:0]    m_req = '0, m_cmd = '0;
  logic [127:0]  m_addr = '0, m_wdata = '0;
  logic [3:0]    m_ack, m_err;
  logic [127:0]  m_rdata;
  logic [2:0]    s_req, s_cmd;
  logic [95:0]   s_addr, s_wdata;
  logic [2:0]    s_ack = '0;
  logic [95:0]   s_rdata = '0;

  int            lat [3];
  logic [31:0]   rdv [3];
  int            cnt [3];
  int            total = 0;
  int            bad = 0;

  crossbar_rr #(.N_MST(4), .N_SLV(3), .ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .master_req(m_req), .master_cmd(m_cmd), .master_addr(m_addr), .master_wdata(m_wdata),
    .master_ack(m_ack), .master_err(m_err), .master_rdata(m_rdata),
    .slave_req(s_req), .slave_cmd(s_cmd), .slave_addr(s_addr), .slave_wdata(s_wdata),
    .slave_ack(s_ack), .slave_rdata(s_rdata)
  );

  always #5 clk = ~clk;

  // Slave responders: ack lat+2 cycles after slave_req first seen (lat=0 -> ack in cycle 2).
  always @(posedge clk) begin
    #1;
    for (int s = 0; s < 3; s++) begin
      if (rst) begin
        s_ack[s] = 1'b0; cnt[s] = 0;
      end else if (s_ack[s]) begin
        s_ack[s] = 1'b0; cnt[s] = 0;
      end else if (s_req[s]) begin
        cnt[s] = cnt[s] + 1;
        if (cnt[s] >= lat[s] + 2) begin
          s_ack[s] = 1'b1;
          s_rdata[s*32 +: 32] = rdv[s];
        end
      end else begin
        cnt[s] = 0;
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic drive(input int m, input logic [31:0] a, input logic c, input logic [31:0] d);
    m_req[m] = 1'b1;
    m_cmd[m] = c;
    m_addr[m*32 +: 32] = a;
    m_wdata[m*32 +: 32] = d;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; m_req = '0;
    for (int s = 0; s < 3; s++) begin lat[s] = 0; rdv[s] = 32'h0; end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_ack(input int m, input int limit, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (m_ack[m]) begin
        ok = 1'b1;
        $display("txn m%0d err=%0b rdata=%08h", m, m_err[m], m_rdata[m*32 +: 32]);
        break;
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int  n, cyc, last_cyc, busy_cnt, unstable, gm;
    int  acks [4];
    bit  prev, ok;

    // Reset state
    do_reset();
    check("rst_sreq", 64'(s_req), 64'h0);
    check("rst_mack", 64'(m_ack), 64'h0);

    // Concurrent read on slave0 and write on slave1
    rdv[0] = 32'h1234_5678;
    rdv[1] = 32'hAAAA_5555;
    drive(0, 32'h0000_0010, 1'b0, 32'h0);
    drive(1, 32'h4000_0004, 1'b1, 32'hDEAD_BEEF);
    @(negedge clk);
    check("t1_sreq", 64'(s_req), 64'h3);
    check("t1_s1_wdata", 64'(s_wdata[63:32]), 64'hDEAD_BEEF);
    check("t1_s1_cmd", 64'(s_cmd[1]), 64'h1);
    check("t1_s0_addr", 64'(s_addr[31:0]), 64'h10);
    @(negedge clk);
    check("t1_ack_early", 64'(m_ack), 64'h0);
    @(negedge clk);
    check("t1_ack", 64'(m_ack), 64'h3);
    check("t1_rdata0", 64'(m_rdata[31:0]), 64'h1234_5678);
    check("t1_rdata1_write", 64'(m_rdata[63:32]), 64'h0);
    check("t1_err", 64'(m_err), 64'h0);
    check("t1_sreq_low", 64'(s_req), 64'h0);
    $display("txn m0 rd rdata=%08h / m1 wr", m_rdata[31:0]);
    m_req = '0;
    @(negedge clk);
    check("t1_ack_pulse", 64'(m_ack), 64'h0);

    // Decode error (idx 3 with 3 slaves); rdata must be forced to 0
    drive(0, 32'hC000_0000, 1'b0, 32'h0);
    @(negedge clk);
    check("t3_ack", 64'(m_ack), 64'h1);
    check("t3_err", 64'(m_err), 64'h1);
    check("t3_rdata", 64'(m_rdata[31:0]), 64'h0);
    check("t3_sreq", 64'(s_req), 64'h0);
    $display("txn m0 decode-error");
    m_req = '0;
    @(negedge clk);
    check("t3_ack_clr", 64'(m_ack | m_err), 64'h0);

    // Fairness: four masters hammering slave0
    do_reset();
    for (int m = 0; m < 4; m++) begin
      drive(m, 32'(m * 256), 1'b0, 32'h0);
      acks[m] = 0;
    end
    n = 0; cyc = 0; last_cyc = 0; prev = 1'b0;
    while (n < 8 && cyc < 60) begin
      @(negedge clk);
      cyc++;
      for (int m = 0; m < 4; m++) if (m_ack[m]) acks[m]++;
      if (s_req[0] && !prev) begin
        gm = int'(s_addr[31:0] >> 8);
        check("t2_order", 64'(gm), 64'(n % 4));
        if (n > 0) check("t2_gap", 64'(cyc - last_cyc), 64'd3);
        $display("txn grant slave0 -> m%0d at cycle %0d", gm, cyc);
        last_cyc = cyc;
        n++;
      end
      prev = s_req[0];
    end
    check("t2_grants", 64'(n), 64'd8);
    check("t2_acks_m0", 64'(acks[0]), 64'd2);
    check("t2_acks_m1", 64'(acks[1]), 64'd2);
    check("t2_acks_m2", 64'(acks[2]), 64'd2);
    check("t2_acks_m3", 64'(acks[3]), 64'd1);
    m_req = '0;
    repeat (6) @(negedge clk);

    // Slow slave0, M1 queued behind M0
    do_reset();
    lat[0] = 5;
    rdv[0] = 32'h0BAD_F00D;
    drive(0, 32'h0000_0020, 1'b0, 32'h0);
    drive(1, 32'h0000_0024, 1'b0, 32'h0);
    ok = 1'b0; busy_cnt = 0; unstable = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (s_req[0] && s_addr[31:0] != 32'h20) unstable++;
      if (s_ack[0]) begin ok = 1'b1; break; end
      if (s_req[0]) busy_cnt++;
    end
    check("t4_ack_seen", 64'(ok), 64'h1);
    check("t4_addr_stable", 64'(unstable), 64'h0);
    check("t4_busy_cycles", 64'(busy_cnt), 64'd6);
    @(negedge clk);
    check("t4_bubble", 64'(s_req[0]), 64'h0);
    check("t4_m0_ack", 64'(m_ack), 64'h1);
    check("t4_m0_rdata", 64'(m_rdata[31:0]), 64'h0BAD_F00D);
    $display("txn m0 rd rdata=%08h", m_rdata[31:0]);
    m_req[0] = 1'b0;
    lat[0] = 0;
    @(negedge clk);
    check("t4_m1_sreq", 64'(s_req[0]), 64'h1);
    check("t4_m1_addr", 64'(s_addr[31:0]), 64'h24);
    wait_ack(1, 10, ok);
    check("t4_m1_done", 64'(ok), 64'h1);
    m_req = '0;
    repeat (2) @(negedge clk);

    // Asynchronous reset during BUSY, then pointer restarts at master 0
    do_reset();
    lat[2] = 5;
    drive(2, 32'h8000_0000, 1'b1, 32'h1111_2222);
    repeat (2) @(negedge clk);
    check("t5_pre_busy", 64'(s_req[2]), 64'h1);
    #2 rst = 1'b1;
    #1;
    check("t5_zero_sreq", 64'(s_req), 64'h0);
    check("t5_zero_slv", 64'(|{s_cmd, s_addr, s_wdata}), 64'h0);
    check("t5_zero_mst", 64'(|{m_ack, m_err, m_rdata}), 64'h0);
    m_req = '0;
    @(negedge clk);
    rst = 1'b0;
    lat[2] = 0;
    rdv[2] = 32'hCAFE_0001;
    drive(1, 32'h8000_0100, 1'b0, 32'h0);
    drive(3, 32'h8000_0300, 1'b0, 32'h0);
    @(negedge clk);
    check("t5_sreq", 64'(s_req[2]), 64'h1);
    check("t5_first_m1", 64'(s_addr[95:64]), 64'h8000_0100);
    wait_ack(1, 10, ok);
    check("t5_m1_done", 64'(ok), 64'h1);
    check("t5_m1_rdata", 64'(m_rdata[63:32]), 64'hCAFE_0001);
    m_req[1] = 1'b0;
    wait_ack(3, 10, ok);
    check("t5_m3_done", 64'(ok), 64'h1);
    m_req = '0;
    repeat (2) @(negedge clk);

    // M0 keeps requesting through its ack while M1 waits: M1 goes next
    do_reset();
    drive(0, 32'h4000_0000, 1'b0, 32'h0);
    @(negedge clk);
    drive(1, 32'h4000_0010, 1'b1, 32'h0000_0055);
    @(negedge clk);
    @(negedge clk);
    check("t6_m0_ack", 64'(m_ack), 64'h1);
    @(negedge clk);
    check("t6_m1_sreq", 64'(s_req[1]), 64'h1);
    check("t6_m1_addr", 64'(s_addr[63:32]), 64'h4000_0010);
    wait_ack(1, 10, ok);
    check("t6_m1_done", 64'(ok), 64'h1);
    m_req[1] = 1'b0;
    @(negedge clk);
    check("t6_m0_again", 64'(s_req[1]), 64'h1);
    check("t6_m0_addr", 64'(s_addr[63:32]), 64'h4000_0000);
    m_req = '0;
    repeat (4) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
